dmem_dump_ctrl: RTL and testbench

- Owns the select and address multiplexing of the data RAM between the pipeline MEM stage and the debug unit.
- On request from the debug unit, and once the pipeline is halted, it walks the data memory word by word.
- Each word is serialised as 4 bytes, LSB first, over a valid/ready byte handshake toward the UART TX path.
- While the controller does not own the memory, the pipeline has it.

---
 rtl/dmem_dump_pkg.sv | 17 +
 rtl/dmem_dump_ctrl_if.sv | 12 +
 rtl/dmem_word_serializer.sv | 62 ++++++
 rtl/dmem_dump_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dmem_dump_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_dump_pkg.sv
// Shared constants for the data-memory dump controller: state encoding,
// word geometry and the byte-to-word address alignment.
package dmem_dump_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_SHIFT     = 2;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t ARM   = 3'd1;
    localparam state_t FETCH = 3'd2;
    localparam state_t SEND  = 3'd3;
    localparam state_t CHK   = 3'd4;
    localparam state_t DONE  = 3'd5;

endpackage

// File: rtl/dmem_dump_ctrl_if.sv
// Byte stream from the dump controller toward the UART TX path (valid/ready).
interface dmem_dump_ctrl_if;
    import dmem_dump_pkg::*;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/dmem_word_serializer.sv
// Splits one loaded RAM word into bytes, LSB first, over a valid/ready
// handshake; flags the acceptance of the final byte of the word.
module dmem_word_serializer
    import dmem_dump_pkg::*;
#(
    parameter int NB_WIDTH = 32,
    parameter int NB_DATA  = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_load,
    input  logic [NB_WIDTH-1:0] i_word,
    input  logic                i_tx_ready,
    output logic [NB_DATA-1:0]  o_tx_data,
    output logic                o_tx_valid,
    output logic                o_last_byte_accepted
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [NB_WIDTH-1:0] shift_q, shift_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic                valid_q, valid_d;
    logic                accept_s;

    // Shift register, byte counter and valid flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shift_q    <= '0;
            byte_cnt_q <= 2'd0;
            valid_q    <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            valid_q    <= valid_d;
        end
    end

    // Load a fresh word, or advance one byte per accepted transfer; data is held while stalled.
    always_comb begin
        accept_s   = valid_q & i_tx_ready;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        valid_d    = valid_q;
        if (i_load) begin
            shift_d    = i_word;
            byte_cnt_d = 2'd0;
            valid_d    = 1'b1;
        end else if (accept_s) begin
            shift_d    = shift_q >> NB_DATA;
            byte_cnt_d = byte_cnt_q + 2'd1;
            valid_d    = (byte_cnt_q != LAST_BYTE);
        end else begin
            valid_d    = valid_q;
        end
    end

    assign o_tx_data            = shift_q[NB_DATA-1:0];
    assign o_tx_valid           = valid_q;
    assign o_last_byte_accepted = accept_s & (byte_cnt_q == LAST_BYTE);

endmodule

// File: rtl/dmem_dump_ctrl.sv
// Data-RAM ownership mux between pipeline and debug unit, plus a word-by-word
// memory dump over a byte stream. Define DMEM_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module dmem_dump_ctrl
    import dmem_dump_pkg::*;
#(
    parameter int NB_WIDTH   = 32,
    parameter int NB_ADDR    = 9,
    parameter int NB_DATA    = 8,
    parameter int DUMP_WORDS = (2 ** NB_ADDR) / 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_dump_start,
    input  logic                i_pipe_halted,
    input  logic                i_pipe_mem_read,
    input  logic                i_pipe_mem_write,
    input  logic [NB_ADDR-1:0]  i_pipe_addr,
    input  logic [NB_WIDTH-1:0] i_ram_data,
    output logic [NB_ADDR-1:0]  o_ram_addr,
    output logic                o_ram_we,
    output logic                o_dunit_sel,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_conflict,
    dmem_dump_ctrl_if.master    tx
);

    localparam int                NB_IDX    = NB_ADDR - ADDR_SHIFT;
    localparam logic [NB_IDX-1:0] LAST_WORD = NB_IDX'(DUMP_WORDS - 1);

    state_t              state_q, state_d;
    logic [NB_IDX-1:0]   word_idx_q, word_idx_d;
    logic                sel_q, sel_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                conflict_q, conflict_d;
    logic                start_acc_s;
    logic                load_s;
    logic                last_byte_s;
    logic [NB_DATA-1:0]  ser_data_s;
    logic                ser_valid_s;

    assign start_acc_s = (state_q == IDLE) & i_dump_start;
    assign load_s      = (state_q == FETCH);

    dmem_word_serializer #(
        .NB_WIDTH (NB_WIDTH),
        .NB_DATA  (NB_DATA)
    ) u_ser (
        .i_clk                (i_clk),
        .i_reset              (i_reset),
        .i_load               (load_s),
        .i_word               (i_ram_data),
        .i_tx_ready           (tx.tx_ready),
        .o_tx_data            (ser_data_s),
        .o_tx_valid           (ser_valid_s),
        .o_last_byte_accepted (last_byte_s)
    );

    // State, word index and registered status outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            sel_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            conflict_q <= conflict_d;
        end
    end

    // Next-state logic; start requests outside IDLE (including the DONE cycle) are dropped.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        case (state_q)
            IDLE: begin
                if (i_dump_start) state_d = ARM;
                else              state_d = IDLE;
            end
            ARM: begin
                if (i_pipe_halted) state_d = FETCH;
                else               state_d = ARM;
            end
            FETCH: state_d = SEND;
            SEND: begin
                if (last_byte_s) begin
                    if (word_idx_q == LAST_WORD) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = FETCH;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            CHK: begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                if (tx.tx_ready) state_d = DONE;
                else             state_d = CHK;
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                word_idx_d = '0;
                state_d    = IDLE;
            end
            default: begin
                word_idx_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the status flops line up with it.
    always_comb begin
        sel_d      = (state_d == FETCH) || (state_d == SEND);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        conflict_d = conflict_q;
        if (start_acc_s) begin
            conflict_d = 1'b0;
        end else if ((i_pipe_mem_read | i_pipe_mem_write) & sel_q) begin
            conflict_d = 1'b1;
        end else begin
            conflict_d = conflict_q;
        end
    end

`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [NB_DATA-1:0] csum_q, csum_d;

    // Running XOR of every data byte handed to the TX path.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) csum_q <= '0;
        else         csum_q <= csum_d;
    end

    // Checksum restarts with each accepted dump request.
    always_comb begin
        csum_d = csum_q;
        if (start_acc_s) begin
            csum_d = '0;
        end else if (ser_valid_s & tx.tx_ready) begin
            csum_d = csum_q ^ ser_data_s;
        end else begin
            csum_d = csum_q;
        end
    end

    assign tx.tx_valid = ser_valid_s | (state_q == CHK);
    assign tx.tx_data  = (state_q == CHK) ? csum_q : ser_data_s;
`else
    assign tx.tx_valid = ser_valid_s;
    assign tx.tx_data  = ser_data_s;
`endif

    assign o_ram_addr  = sel_q ? {word_idx_q, 2'b00} : i_pipe_addr;
    assign o_ram_we    = i_pipe_mem_write & ~sel_q;
    assign o_dunit_sel = sel_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_conflict  = conflict_q;

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Directed bench for dmem_dump_ctrl: full dumps under steady and throttled
// TX ready, halt-gated start, pipeline conflict, reset abort, optional checksum.
module tb_dmem_dump_ctrl;

    localparam int NWORDS = 128;
`ifdef DMEM_DUMP_CHECKSUM_EN
    localparam int NBYTES = 4 * NWORDS + 1;
`else
    localparam int NBYTES = 4 * NWORDS;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dump_start;
    logic        pipe_halted;
    logic        pipe_rd;
    logic        pipe_wr;
    logic [8:0]  pipe_addr;
    logic [31:0] ram_data;
    logic [8:0]  ram_addr;
    logic        ram_we;
    logic        sel;
    logic        busy;
    logic        done;
    logic        conflict;

    logic [31:0] word_mem [NWORDS];
    logic [7:0]  got_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_writes = 0;

    dmem_dump_ctrl_if tx_if ();

    dmem_dump_ctrl dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_dump_start     (dump_start),
        .i_pipe_halted    (pipe_halted),
        .i_pipe_mem_read  (pipe_rd),
        .i_pipe_mem_write (pipe_wr),
        .i_pipe_addr      (pipe_addr),
        .i_ram_data       (ram_data),
        .o_ram_addr       (ram_addr),
        .o_ram_we         (ram_we),
        .o_dunit_sel      (sel),
        .o_busy           (busy),
        .o_done           (done),
        .o_conflict       (conflict),
        .tx               (tx_if)
    );

    always #5 clk = ~clk;

    assign ram_data = word_mem[ram_addr[8:2]];

    // Any write strobe reaching the RAM at a clock edge is counted.
    always @(posedge clk) begin
        if (ram_we) n_writes <= n_writes + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // mode 0: ready always high, mode 1: ready one cycle in three (halt dropped mid-dump).
    task automatic run_dump(input int mode, input int halt_delay, input int inject_at, input int abort_at);
        logic [7:0] exp_q [$];
        logic [7:0] csum;
        logic [7:0] held;
        logic       held_v;
        int idx, nacc, first, last_acc, done_idx, timing_err, stall_err, arm_err;
        bit fin, injected;
        csum = 8'h00;
        for (int w = 0; w < NWORDS; w++) begin
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(8'(word_mem[w] >> (8 * b)));
                csum = csum ^ 8'(word_mem[w] >> (8 * b));
            end
        end
`ifdef DMEM_DUMP_CHECKSUM_EN
        exp_q.push_back(csum);
`endif
        got_q.delete();
        idx = 0; nacc = 0; last_acc = -1; done_idx = -2;
        timing_err = 0; stall_err = 0; arm_err = 0;
        held = 8'h00; held_v = 1'b0; fin = 1'b0; injected = 1'b0;
        first = (halt_delay == 0) ? 3 : halt_delay + 2;
        @(negedge clk);
        dump_start     = 1'b1;
        pipe_halted    = (halt_delay == 0);
        pipe_addr      = 9'h040;
        tx_if.tx_ready = 1'b1;
        while (!fin) begin
            @(negedge clk);
            idx++;
            dump_start = 1'b0;
            if (idx == 1) begin
                check_val("busy_in_arm", {31'd0, busy}, 32'd1);
                check_val("conflict_cleared_by_start", {31'd0, conflict}, 32'd0);
            end
            if (idx <= halt_delay) begin
                if (sel || !busy || tx_if.tx_valid || ram_addr != pipe_addr) arm_err++;
            end
            if (idx == halt_delay) pipe_halted = 1'b1;
            if (mode == 1) begin
                tx_if.tx_ready = (idx % 3 == 0);
                if (idx == 200) pipe_halted = 1'b0;
                if (idx == 210) check_val("sel_kept_after_halt_drop", {31'd0, sel}, 32'd1);
            end else begin
                tx_if.tx_ready = 1'b1;
            end
            if (nacc == abort_at) tx_if.tx_ready = 1'b0;
            if (held_v && (!tx_if.tx_valid || tx_if.tx_data != held)) stall_err++;
            held_v = tx_if.tx_valid && !tx_if.tx_ready;
            held   = tx_if.tx_data;
            if (abort_at >= 0 && nacc == abort_at && tx_if.tx_valid) begin
                check_val("pending_byte_w5_b2", {24'd0, tx_if.tx_data}, {24'd0, exp_q[nacc]});
                #2 rst = 1'b1;
                #1;
                check_val("async_reset_outputs",
                          {19'd0, sel, tx_if.tx_valid, tx_if.tx_data, busy, done, conflict}, 32'd0);
                check_val("reset_addr_is_pipe", {23'd0, ram_addr}, 32'h040);
                fin = 1'b1;
            end else if (tx_if.tx_valid && tx_if.tx_ready) begin
                if (nacc < NBYTES)
                    check_val($sformatf("byte%0d", nacc), {24'd0, tx_if.tx_data}, {24'd0, exp_q[nacc]});
                if (mode == 0 && nacc < 4 * NWORDS && idx != first + 5 * (nacc / 4) + nacc % 4)
                    timing_err++;
                got_q.push_back(tx_if.tx_data);
                last_acc = idx;
                nacc++;
            end
            if (inject_at >= 0 && nacc == inject_at && !injected) begin
                pipe_wr   = 1'b1;
                pipe_addr = 9'h008;
                #1;
                check_val("we_gated_while_owned", {31'd0, ram_we}, 32'd0);
                check_val("addr_owned_word3", {23'd0, ram_addr}, 32'h00C);
                injected = 1'b1;
            end else if (injected) begin
                pipe_wr   = 1'b0;
                pipe_addr = 9'h040;
            end
            if (!fin && done) begin
                done_idx   = idx;
                dump_start = 1'b1;
                @(negedge clk);
                dump_start = 1'b0;
                check_val("start_on_done_ignored", {31'd0, busy}, 32'd0);
                check_val("done_one_pulse", {31'd0, done}, 32'd0);
                fin = 1'b1;
            end
            if (!fin && idx > 6000) begin
                check_val("timeout_waiting_done", 32'd0, 32'd1);
                fin = 1'b1;
            end
        end
        if (abort_at < 0) begin
            check_val("byte_count", nacc, NBYTES);
            check_val("done_after_last_byte", done_idx, last_acc + 1);
            check_val("timing_errors", timing_err, 32'd0);
            check_val("stall_errors", stall_err, 32'd0);
            if (halt_delay > 0) check_val("arm_wait_errors", arm_err, 32'd0);
        end
    endtask

    initial begin
        logic [7:0] hand [8];
        hand = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        for (int i = 0; i < NWORDS; i++)
            word_mem[i] = {8'(i) ^ 8'h5A, 8'(i), 8'hC3, ~8'(i)};
        word_mem[0] = 32'h11223344;
        word_mem[1] = 32'hAABBCCDD;
        word_mem[2] = 32'h01020304;
        word_mem[3] = 32'hF0E0D0C0;
        rst = 1'b1; dump_start = 1'b0; pipe_halted = 1'b0;
        pipe_rd = 1'b0; pipe_wr = 1'b0; pipe_addr = 9'h000;
        tx_if.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs",
                  {19'd0, sel, tx_if.tx_valid, tx_if.tx_data, busy, done, conflict}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Steady ready: byte order and 5-cycle word rate.
        run_dump(0, 0, -1, -1);
        for (int i = 0; i < 8; i++)
            check_val($sformatf("hand_byte%0d", i), {24'd0, got_q[i]}, {24'd0, hand[i]});

        // Throttled ready with halt dropped mid-dump.
        run_dump(1, 0, -1, -1);

        // Pipeline keeps the RAM until halt arrives.
        run_dump(0, 10, -1, -1);

        // Unowned pipeline write passes through.
        @(negedge clk);
        pipe_wr = 1'b1;
        #1 check_val("we_passes_when_idle", {31'd0, ram_we}, 32'd1);
        pipe_wr = 1'b0;

        // Pipeline write during the dump is blocked and flagged.
        run_dump(0, 0, 13, -1);
        check_val("conflict_sticky_after_done", {31'd0, conflict}, 32'd1);
        check_val("no_ram_writes", n_writes, 32'd0);

        // Reset mid-dump, then a clean restart from word 0.
        run_dump(0, 0, -1, 22);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_dump(0, 0, -1, -1);

`ifdef DMEM_DUMP_CHECKSUM_EN
        for (int i = 0; i < NWORDS; i++) word_mem[i] = 32'h01010101;
        run_dump(0, 0, -1, -1);
        check_val("checksum_byte", {24'd0, got_q[NBYTES-1]}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
